// File: rtl/io_ep_pkg.sv
// -----------------------------------------------------------------------------
// io_ep_pkg
//   Shared constants for the processor I/O device endpoint:
//   - IO_W: width of one transferred byte
//   - default FIFO depths and default in_dev_ack timeout
//   - 2-bit state encodings for the TX (device->processor) and
//     RX (processor->device) handshake FSMs
// -----------------------------------------------------------------------------
package io_ep_pkg;

  localparam int IO_W          = 8;

  localparam int IN_DEPTH_DEF  = 4;
  localparam int OUT_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;

  // TX FSM: present a byte to the processor and run the 4-phase handshake
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_PRES = 2'd1;
  localparam logic [1:0] TX_REL  = 2'd2;

  // RX FSM: accept a byte from the processor
  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_ACK  = 2'd1;

endpackage

// File: rtl/io_ep_fifo.sv
// -----------------------------------------------------------------------------
// io_ep_fifo
//   Synchronous FIFO with first-word-fall-through head (rdata shows the oldest
//   entry combinationally). DEPTH must be a power of two, >= 2, so the
//   pointers wrap naturally.
//   Ports:
//     g_clk  in   clock, rising edge
//     g_clr  in   asynchronous active-low reset (empties the FIFO)
//     push   in   write wdata (ignored when full unless popping in same cycle)
//     wdata  in   W-bit write data
//     pop    in   drop head entry (ignored when empty)
//     rdata  out  head entry
//     full   out  count == DEPTH
//     empty  out  count == 0
//     count  out  number of stored entries
// -----------------------------------------------------------------------------
module io_ep_fifo
  import io_ep_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = IO_W
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    // A pop from empty is dropped. A push while full is only accepted when a
    // pop frees the slot in the same cycle, leaving the count unchanged.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge g_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/io_dev_endpoint.sv
// -----------------------------------------------------------------------------
// io_dev_endpoint
//   Device side of the processor's 4-phase I/O handshakes.
//   - Input direction: bytes from a local source are buffered in the in-FIFO
//     and presented on input_bus / in_dev_hs until the processor acks.
//   - Output direction: bytes on output_bus are captured into the out-FIFO
//     and acknowledged with out_dev_ack; a local sink drains the FIFO.
//   Optional feature (macro IO_TIMEOUT_EN): if the processor does not ack a
//   presented byte within TIMEOUT cycles, the handshake is withdrawn, the byte
//   is kept, timeout_err is set (sticky) and the byte is presented again.
//   Without the macro there is no TIMEOUT parameter and timeout_err is 0.
//   Ports:
//     g_clk        in   clock, rising edge
//     g_clr        in   asynchronous active-low reset
//     src_valid    in   local source has a byte
//     src_data     in   local source byte
//     src_ready    out  in-FIFO not full
//     input_bus    out  byte presented to the processor
//     in_dev_hs    out  byte on input_bus is valid
//     in_dev_ack   in   processor has taken the byte
//     output_bus   in   byte from the processor
//     out_dev_req  in   processor byte valid on output_bus
//     out_dev_hs   out  endpoint can accept a byte
//     out_dev_ack  out  endpoint has captured the byte
//     snk_valid    out  out-FIFO not empty
//     snk_data     out  out-FIFO head
//     snk_ready    in   local sink pops the head
//     timeout_err  out  sticky in_dev_ack timeout flag
// -----------------------------------------------------------------------------
module io_dev_endpoint
  import io_ep_pkg::*;
#(
  parameter int IN_DEPTH  = IN_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
`ifdef IO_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic            g_clk,
  input  logic            g_clr,
  input  logic            src_valid,
  input  logic [IO_W-1:0] src_data,
  output logic            src_ready,
  output logic [IO_W-1:0] input_bus,
  output logic            in_dev_hs,
  input  logic            in_dev_ack,
  input  logic [IO_W-1:0] output_bus,
  input  logic            out_dev_req,
  output logic            out_dev_hs,
  output logic            out_dev_ack,
  output logic            snk_valid,
  output logic [IO_W-1:0] snk_data,
  input  logic            snk_ready,
  output logic            timeout_err
);

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  logic                        in_push, in_pop, in_full, in_empty;
  logic [IO_W-1:0]             in_head;
  logic [$clog2(IN_DEPTH):0]   in_count;
  logic                        out_push, out_pop, out_full, out_empty;
  logic [$clog2(OUT_DEPTH):0]  out_count;
  logic                        unused_counts;

  assign src_ready = !in_full;
  assign in_push   = src_valid && src_ready;
  assign snk_valid = !out_empty;
  assign out_pop   = snk_valid && snk_ready;

  // Occupancy counts are available for debug taps but not needed here.
  assign unused_counts = ^{in_count, out_count};

  io_ep_fifo #(
    .DEPTH (IN_DEPTH),
    .W     (IO_W)
  ) u_in_fifo (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .push  (in_push),
    .wdata (src_data),
    .pop   (in_pop),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  io_ep_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (IO_W)
  ) u_out_fifo (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .push  (out_push),
    .wdata (output_bus),
    .pop   (out_pop),
    .rdata (snk_data),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // ---------------------------------------------------------------------------
  // TX FSM: in-FIFO head -> processor
  // ---------------------------------------------------------------------------
  logic [1:0]      tx_state_q, tx_state_d;
  logic [IO_W-1:0] input_bus_q, input_bus_d;
  logic            in_dev_hs_q, in_dev_hs_d;

`ifdef IO_TIMEOUT_EN
  // Counter value on the last allowed TX_PRES cycle; in_dev_hs stays high
  // for exactly TIMEOUT cycles before being withdrawn.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] to_cnt_q, to_cnt_d;
  logic       timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    tx_state_d  = tx_state_q;
    input_bus_d = input_bus_q;
    in_dev_hs_d = in_dev_hs_q;
    in_pop      = 1'b0;
`ifdef IO_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        // in_dev_ack is deliberately not looked at here.
        if (!in_empty) begin
          tx_state_d  = TX_PRES;
          input_bus_d = in_head;
          in_dev_hs_d = 1'b1;
`ifdef IO_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      TX_PRES: begin
        // An ack arriving on the final allowed cycle still wins over timeout.
        if (in_dev_ack) begin
          in_pop      = 1'b1;
          in_dev_hs_d = 1'b0;
          tx_state_d  = TX_REL;
        end
`ifdef IO_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Withdraw without popping; TX_IDLE re-presents the same head.
          in_dev_hs_d   = 1'b0;
          timeout_err_d = 1'b1;
          tx_state_d    = TX_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      TX_REL: begin
        // input_bus keeps the byte until the processor releases its ack.
        if (!in_dev_ack) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        in_dev_hs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      tx_state_q  <= TX_IDLE;
      input_bus_q <= '0;
      in_dev_hs_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      input_bus_q <= input_bus_d;
      in_dev_hs_q <= in_dev_hs_d;
    end
  end

`ifdef IO_TIMEOUT_EN
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign input_bus = input_bus_q;
  assign in_dev_hs = in_dev_hs_q;

  // ---------------------------------------------------------------------------
  // RX FSM: processor -> out-FIFO
  // ---------------------------------------------------------------------------
  logic [1:0] rx_state_q, rx_state_d;
  logic       out_dev_hs_q, out_dev_hs_d;
  logic       out_dev_ack_q, out_dev_ack_d;

  always_comb begin
    rx_state_d    = rx_state_q;
    out_dev_hs_d  = out_dev_hs_q;
    out_dev_ack_d = out_dev_ack_q;
    out_push      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Capture only when we were advertising space; out_dev_hs=1 implies
        // the FIFO was not full, since only this FSM ever pushes into it.
        if (out_dev_req && out_dev_hs_q) begin
          out_push      = 1'b1;
          out_dev_ack_d = 1'b1;
          out_dev_hs_d  = 1'b0;
          rx_state_d    = RX_ACK;
        end else begin
          out_dev_hs_d  = !out_full;
        end
      end
      RX_ACK: begin
        if (!out_dev_req) begin
          out_dev_ack_d = 1'b0;
          out_dev_hs_d  = !out_full;
          rx_state_d    = RX_IDLE;
        end
      end
      default: begin
        rx_state_d    = RX_IDLE;
        out_dev_hs_d  = 1'b0;
        out_dev_ack_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      rx_state_q    <= RX_IDLE;
      out_dev_hs_q  <= 1'b0;
      out_dev_ack_q <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      out_dev_hs_q  <= out_dev_hs_d;
      out_dev_ack_q <= out_dev_ack_d;
    end
  end

  assign out_dev_hs  = out_dev_hs_q;
  assign out_dev_ack = out_dev_ack_q;

endmodule

// File: tb/tb_io_dev_endpoint.sv
// -----------------------------------------------------------------------------
// tb_io_dev_endpoint
//   Directed bench for io_dev_endpoint (IN_DEPTH=OUT_DEPTH=4; TIMEOUT=10 when
//   IO_TIMEOUT_EN is defined). Inputs change 1 time unit after a rising edge,
//   outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_io_dev_endpoint;

  logic       g_clk = 1'b0;
  logic       g_clr;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic [7:0] input_bus;
  logic       in_dev_hs;
  logic       in_dev_ack;
  logic [7:0] output_bus;
  logic       out_dev_req;
  logic       out_dev_hs;
  logic       out_dev_ack;
  logic       snk_valid;
  logic [7:0] snk_data;
  logic       snk_ready;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  io_dev_endpoint #(
    .IN_DEPTH  (4),
    .OUT_DEPTH (4)
`ifdef IO_TIMEOUT_EN
    , .TIMEOUT (10)
`endif
  ) dut (
    .g_clk       (g_clk),
    .g_clr       (g_clr),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .input_bus   (input_bus),
    .in_dev_hs   (in_dev_hs),
    .in_dev_ack  (in_dev_ack),
    .output_bus  (output_bus),
    .out_dev_req (out_dev_req),
    .out_dev_hs  (out_dev_hs),
    .out_dev_ack (out_dev_ack),
    .snk_valid   (snk_valid),
    .snk_data    (snk_data),
    .snk_ready   (snk_ready),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Processor write with a normal (unstalled) handshake.
  task automatic proc_write(input logic [7:0] b);
    output_bus  = b;
    out_dev_req = 1'b1;
    tick();
    check("wr_ack_high", out_dev_ack, 1);
    out_dev_req = 1'b0;
    tick();
    check("wr_ack_low", out_dev_ack, 0);
    $display("[%0t] proc write %02h captured", $time, b);
  endtask

  // Hard stop in case something never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] drain_exp [4];
    int         hs_cycles;

    g_clr       = 1'b0;
    src_valid   = 1'b0;
    src_data    = 8'h00;
    in_dev_ack  = 1'b0;
    output_bus  = 8'h00;
    out_dev_req = 1'b0;
    snk_ready   = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_input_bus", input_bus, 0);
    check("rst_in_dev_hs", in_dev_hs, 0);
    check("rst_out_dev_hs", out_dev_hs, 0);
    check("rst_out_dev_ack", out_dev_ack, 0);
    check("rst_snk_valid", snk_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_src_ready", src_ready, 1);
    tick();
    tick();
    g_clr = 1'b1;
    tick();
    check("post_rst_out_dev_hs", out_dev_hs, 1);
    check("post_rst_in_dev_hs", in_dev_hs, 0);

    // ---------------- 1: single byte A5 to processor ----------------
    src_valid = 1'b1;
    src_data  = 8'hA5;
    tick();
    src_valid = 1'b0;
    check("t1_hs_not_yet", in_dev_hs, 0);
    tick();
    check("t1_hs_up", in_dev_hs, 1);
    check("t1_bus", input_bus, 8'hA5);
    tick();
    check("t1_bus_stable", input_bus, 8'hA5);
    in_dev_ack = 1'b1;
    tick();
    check("t1_hs_drop", in_dev_hs, 0);
    check("t1_bus_held", input_bus, 8'hA5);
    in_dev_ack = 1'b0;
    tick();
    tick();
    check("t1_no_repeat", in_dev_hs, 0);
    check("t1_src_ready", src_ready, 1);
    $display("[%0t] tx byte a5 delivered", $time);

    // ---------------- 2: 5 bytes into depth-4 FIFO, ack withheld ----------------
    src_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      src_data = 8'(i);
      tick();
      check("t2_src_ready_fill", src_ready, (i == 4) ? 0 : 1);
    end
    src_data = 8'd5;
    tick();
    check("t2_full_holds", src_ready, 0);
    for (int i = 1; i <= 5; i++) begin
      check("t2_hs", in_dev_hs, 1);
      check("t2_order", input_bus, i);
      in_dev_ack = 1'b1;
      tick();
      check("t2_hs_drop", in_dev_hs, 0);
      in_dev_ack = 1'b0;
      tick();
      if (i == 1) begin
        // The freed slot takes byte 5 on this edge.
        check("t2_refill_full", src_ready, 0);
        src_valid = 1'b0;
      end
      tick();
      $display("[%0t] tx byte %02h delivered", $time, i);
    end
    check("t2_done_hs", in_dev_hs, 0);
    check("t2_done_ready", src_ready, 1);

    // ---------------- 3: processor writes 3C ----------------
    output_bus  = 8'h3C;
    out_dev_req = 1'b1;
    tick();
    check("t3_ack", out_dev_ack, 1);
    check("t3_hs_low", out_dev_hs, 0);
    check("t3_snk_valid", snk_valid, 1);
    check("t3_snk_data", snk_data, 8'h3C);
    tick();
    check("t3_ack_held", out_dev_ack, 1);
    out_dev_req = 1'b0;
    tick();
    check("t3_ack_rel", out_dev_ack, 0);
    check("t3_hs_back", out_dev_hs, 1);
    snk_ready = 1'b1;
    tick();
    snk_ready = 1'b0;
    check("t3_popped", snk_valid, 0);
    $display("[%0t] proc write 3c captured and drained", $time);

    // ---------------- 4: out-FIFO full hold-off ----------------
    for (int i = 1; i <= 4; i++) begin
      proc_write(8'h10 + 8'(i));
    end
    check("t4_hs_full", out_dev_hs, 0);
    output_bus  = 8'h55;
    out_dev_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_held_ack", out_dev_ack, 0);
      check("t4_held_hs", out_dev_hs, 0);
    end
    check("t4_head", snk_data, 8'h11);
    snk_ready = 1'b1;
    tick();
    snk_ready = 1'b0;
    check("t4_after_pop_ack", out_dev_ack, 0);
    tick();
    check("t4_hs_reopen", out_dev_hs, 1);
    check("t4_no_ack_yet", out_dev_ack, 0);
    tick();
    check("t4_5th_ack", out_dev_ack, 1);
    out_dev_req = 1'b0;
    tick();
    check("t4_5th_rel", out_dev_ack, 0);
    check("t4_full_again", out_dev_hs, 0);
    $display("[%0t] proc write 55 captured after hold-off", $time);
    drain_exp[0] = 8'h12;
    drain_exp[1] = 8'h13;
    drain_exp[2] = 8'h14;
    drain_exp[3] = 8'h55;
    snk_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_drain_valid", snk_valid, 1);
      check("t4_drain_data", snk_data, drain_exp[k]);
      tick();
    end
    snk_ready = 1'b0;
    check("t4_drained", snk_valid, 0);
    tick();
    check("t4_hs_idle", out_dev_hs, 1);

    // ---------------- 5: reset during TX_PRES and RX_ACK ----------------
    src_valid   = 1'b1;
    src_data    = 8'h77;
    output_bus  = 8'h99;
    out_dev_req = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    check("t5_pres", in_dev_hs, 1);
    check("t5_ack", out_dev_ack, 1);
    check("t5_snk_valid", snk_valid, 1);
    g_clr = 1'b0;
    #1;
    check("t5_rst_bus", input_bus, 0);
    check("t5_rst_in_hs", in_dev_hs, 0);
    check("t5_rst_out_hs", out_dev_hs, 0);
    check("t5_rst_ack", out_dev_ack, 0);
    check("t5_rst_snk_valid", snk_valid, 0);
    check("t5_rst_src_ready", src_ready, 1);
    out_dev_req = 1'b0;
    tick();
    g_clr = 1'b1;
    tick();
    check("t5_empty_out", snk_valid, 0);
    check("t5_in_idle", in_dev_hs, 0);
    check("t5_out_hs", out_dev_hs, 1);
    tick();
    check("t5_in_still_empty", in_dev_hs, 0);
    $display("[%0t] reset mid-transfer cleared both directions", $time);

    // ---------------- 6: in_dev_ack timeout ----------------
    src_valid = 1'b1;
    src_data  = 8'hC3;
    tick();
    src_valid = 1'b0;
    tick();
    check("t6_hs_up", in_dev_hs, 1);
`ifdef IO_TIMEOUT_EN
    hs_cycles = 0;
    for (int n = 0; n < 40 && in_dev_hs; n++) begin
      hs_cycles++;
      tick();
    end
    check("t6_hs_cycles", hs_cycles, 10);
    check("t6_hs_dropped", in_dev_hs, 0);
    check("t6_err_set", timeout_err, 1);
    tick();
    check("t6_represent_hs", in_dev_hs, 1);
    check("t6_represent_bus", input_bus, 8'hC3);
    in_dev_ack = 1'b1;
    tick();
    check("t6_acked", in_dev_hs, 0);
    check("t6_err_sticky", timeout_err, 1);
    in_dev_ack = 1'b0;
    tick();
    tick();
    check("t6_popped", in_dev_hs, 0);
    $display("[%0t] tx byte c3 timed out, re-presented, delivered", $time);
`else
    // Without the timeout the byte is held for as long as the processor waits.
    hs_cycles = 0;
    for (int n = 0; n < 300 && in_dev_hs; n++) begin
      hs_cycles++;
      tick();
    end
    check("t6_hs_cycles", hs_cycles, 300);
    check("t6_bus_held", input_bus, 8'hC3);
    check("t6_no_err", timeout_err, 0);
    in_dev_ack = 1'b1;
    tick();
    check("t6_acked", in_dev_hs, 0);
    in_dev_ack = 1'b0;
    tick();
    tick();
    check("t6_popped", in_dev_hs, 0);
    $display("[%0t] tx byte c3 held 300 cycles then delivered", $time);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
